// File: rtl/assoc_cache.sv
// Set-associative read cache with block refill over a req/ack memory port.
// Handles one request at a time: IDLE -> LOOKUP -> (FETCH) -> RESP.
module assoc_cache #(
    parameter int ADDR_W      = 15,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int SETS        = 128,
    parameter int WAYS        = 2,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic [ADDR_W-1:0]             req_addr,
    output logic                          req_ready,
    output logic                          resp_valid,
    output logic [WORD_W-1:0]             resp_data,
    output logic                          resp_hit,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ack,
    input  logic [BLOCK_WORDS*WORD_W-1:0] mem_data,
    output logic [CNT_W-1:0]              hit_count,
    output logic [CNT_W-1:0]              access_count
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BLK_W = BLOCK_WORDS * WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FETCH,
        RESP
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [ADDR_W-1:0] r_addr;
    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [BLK_W-1:0]  r_data  [SETS][WAYS];
    logic [WAY_W-1:0]  r_ptr   [SETS];

    logic              r_respValid;
    logic              r_respHit;
    logic [WORD_W-1:0] r_respData;
    logic              r_memReq;
    logic [ADDR_W-1:0] r_memAddr;
    logic [CNT_W-1:0]  r_hitCount;
    logic [CNT_W-1:0]  r_accessCount;

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hitWay;
    logic              w_anyInvalid;
    logic [WAY_W-1:0]  w_victim;
    logic [BLK_W-1:0]  w_hitBlock;
    logic [WORD_W-1:0] w_hitWord;
    logic [WORD_W-1:0] w_fillWord;
    logic              w_fill;
    logic              w_respond;

    assign w_off = r_addr[OFF_W-1:0];
    assign w_idx = r_addr[OFF_W +: IDX_W];
    assign w_tag = r_addr[ADDR_W-1 -: TAG_W];

    // Parallel tag compare across all ways of the latched set.
    always_comb begin
        w_hit    = 1'b0;
        w_hitWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit    = 1'b1;
                w_hitWay = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; the round-robin pointer is used only when the set is full.
    always_comb begin
        w_anyInvalid = 1'b0;
        w_victim     = r_ptr[w_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_anyInvalid = 1'b1;
                w_victim     = WAY_W'(w);
            end
        end
    end

    assign w_hitBlock = r_data[w_idx][w_hitWay];
    assign w_hitWord  = w_hitBlock[w_off*WORD_W +: WORD_W];
    assign w_fillWord = mem_data[w_off*WORD_W +: WORD_W];
    assign w_fill     = (r_state == FETCH) && mem_ack;
    assign w_respond  = ((r_state == LOOKUP) && w_hit) || w_fill;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_nextState = LOOKUP;
            LOOKUP:  w_nextState = w_hit ? RESP : FETCH;
            FETCH:   if (mem_ack) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr        <= '0;
            r_respValid   <= 1'b0;
            r_respHit     <= 1'b0;
            r_respData    <= '0;
            r_memReq      <= 1'b0;
            r_memAddr     <= '0;
            r_hitCount    <= '0;
            r_accessCount <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else begin
            r_respValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) r_addr <= req_addr;
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_respValid <= 1'b1;
                        r_respHit   <= 1'b1;
                        r_respData  <= w_hitWord;
                    end else begin
                        r_memReq  <= 1'b1;
                        r_memAddr <= {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        r_memReq             <= 1'b0;
                        r_respValid          <= 1'b1;
                        r_respHit            <= 1'b0;
                        r_respData           <= w_fillWord;
                        r_valid[w_idx][w_victim] <= 1'b1;
                        if (!w_anyInvalid && (WAYS > 1)) r_ptr[w_idx] <= r_ptr[w_idx] + 1'b1;
                    end
                end
                default: ;
            endcase
            // Counters saturate rather than wrap.
            if (w_respond) begin
                if (r_accessCount != '1) r_accessCount <= r_accessCount + 1'b1;
                if ((r_state == LOOKUP) && (r_hitCount != '1)) r_hitCount <= r_hitCount + 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx][w_victim]  <= w_tag;
            r_data[w_idx][w_victim] <= mem_data;
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign resp_valid   = r_respValid;
    assign resp_hit     = r_respHit;
    assign resp_data    = r_respData;
    assign mem_req      = r_memReq;
    assign mem_addr     = r_memAddr;
    assign hit_count    = r_hitCount;
    assign access_count = r_accessCount;

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed reads against a set/way behavioural model,
// plus a CNT_W=4 instance sharing the same stimulus to watch counter saturation.
module tb_assoc_cache;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [14:0]  req_addr = '0;
    logic         mem_ack = 1'b0;
    logic [127:0] memData;

    logic         req_ready, resp_valid, resp_hit, mem_req;
    logic [31:0]  resp_data;
    logic [14:0]  mem_addr;
    logic [15:0]  hit_count, access_count;

    logic         satReady, satValid, satHit, satMemReq;
    logic [31:0]  satData;
    logic [14:0]  satMemAddr;
    logic [3:0]   satHitCount, satAccCount;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    assoc_cache dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_hit(resp_hit), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(memData), .hit_count(hit_count),
        .access_count(access_count)
    );

    assoc_cache #(.CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(satReady), .resp_valid(satValid), .resp_data(satData),
        .resp_hit(satHit), .mem_req(satMemReq), .mem_addr(satMemAddr),
        .mem_ack(mem_ack), .mem_data(memData), .hit_count(satHitCount),
        .access_count(satAccCount)
    );

    // Main memory contents: each word is a fixed function of its address.
    function automatic logic [31:0] memWord(input logic [14:0] a);
        logic [31:0] ext;
        ext = {17'd0, a};
        return 32'hC0DE0000 ^ (ext << 4) ^ ext;
    endfunction

    always_comb begin
        memData = '0;
        for (int i = 0; i < 4; i++) memData[i*32 +: 32] = memWord({mem_addr[14:2], 2'(i)});
    end

    // Behavioural cache model: 128 sets x 2 ways, tag = addr/512.
    typedef struct {
        logic [31:0] data;
        bit          hit;
    } exp_t;

    bit          mValid [128][2];
    int          mTag   [128][2];
    int          mPtr   [128];
    exp_t        expQ [$];
    int          mHits, mAcc;
    logic [31:0] lastData;
    bit          lastHit;

    function automatic int satVal(input int v, input int maxV);
        return (v > maxV) ? maxV : v;
    endfunction

    task automatic modelClear();
        for (int s = 0; s < 128; s++) begin
            mValid[s][0] = 0;
            mValid[s][1] = 0;
            mPtr[s] = 0;
        end
        expQ.delete();
        mHits = 0;
        mAcc = 0;
        lastData = '0;
        lastHit = 0;
    endtask

    task automatic modelAccess(input int a, output bit hit);
        int idx, tag, v;
        idx = (a / 4) % 128;
        tag = a / 512;
        hit = 0;
        for (int w = 0; w < 2; w++)
            if (mValid[idx][w] && mTag[idx][w] == tag) hit = 1;
        if (!hit) begin
            v = -1;
            for (int w = 0; w < 2; w++)
                if (!mValid[idx][w] && v < 0) v = w;
            if (v < 0) begin
                v = mPtr[idx];
                mPtr[idx] = (mPtr[idx] + 1) % 2;
            end
            mValid[idx][v] = 1;
            mTag[idx][v] = tag;
        end
        expQ.push_back('{memWord(15'(a)), hit});
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of responses, held values and counters against the model.
    always @(negedge clk) begin : compareProc
        exp_t e;
        if (!rst) begin
            if (resp_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_resp", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resp_data", resp_data, e.data);
                    checkOutput("resp_hit", resp_hit, e.hit);
                    mAcc++;
                    if (e.hit) mHits++;
                    lastData = e.data;
                    lastHit = e.hit;
                end
            end else begin
                checkOutput("resp_data_hold", resp_data, lastData);
                checkOutput("resp_hit_hold", resp_hit, lastHit);
            end
            checkOutput("hit_count", hit_count, satVal(mHits, 65535));
            checkOutput("access_count", access_count, satVal(mAcc, 65535));
            checkOutput("sat_hit_count", satHitCount, satVal(mHits, 15));
            checkOutput("sat_access_count", satAccCount, satVal(mAcc, 15));
        end
    end

    task automatic doReset();
        req_valid = 0;
        mem_ack = 0;
        rst = 1;
        modelClear();
        #1;
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_hit", resp_hit, 0);
        checkOutput("rst_resp_data", resp_data, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_hit_count", hit_count, 0);
        checkOutput("rst_access_count", access_count, 0);
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // One read, starting and ending at a negedge. expHitLit < 0 means no literal pin.
    task automatic applyStimulus(input logic [14:0] addr, input int ackDelay,
                                 input int expHitLit, input logic [31:0] expDataLit,
                                 input bit checkData);
        bit hit, done;
        int k, reqCycles;
        logic [14:0] blk;
        blk = {addr[14:2], 2'b00};
        checkOutput("req_ready_idle", req_ready, 1);
        req_valid = 1;
        req_addr = addr;
        @(posedge clk);
        modelAccess(int'(addr), hit);
        @(negedge clk);
        req_valid = 0;
        k = 1;
        reqCycles = 0;
        done = 0;
        while (!done && k < 60) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            mem_ack = 0;
            if (resp_valid) begin
                done = 1;
                checkOutput("latency", k, hit ? 2 : 3 + ackDelay);
                checkOutput("mem_req_after_resp", mem_req, 0);
                checkOutput("req_cycles", reqCycles, hit ? 0 : ackDelay + 1);
                if (expHitLit >= 0) checkOutput("resp_hit_lit", resp_hit, 64'(expHitLit));
                if (checkData) checkOutput("resp_data_lit", resp_data, expDataLit);
            end else if (mem_req) begin
                reqCycles++;
                checkOutput("mem_addr_stable", mem_addr, blk);
                checkOutput("req_ready_busy", req_ready, 0);
                if (reqCycles == ackDelay + 1) mem_ack = 1;
            end
        end
        if (!done) checkOutput("resp_timeout", 0, 1);
        mem_ack = 0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("single_pulse", resp_valid, 0);
        checkOutput("req_ready_back", req_ready, 1);
    endtask

    task automatic resetMidFetch();
        req_valid = 1;
        req_addr = 15'd1024;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midfetch_mem_req_up", mem_req, 1);
        #2;
        rst = 1;
        modelClear();
        #1;
        checkOutput("midfetch_mem_req_async", mem_req, 0);
        checkOutput("midfetch_mem_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        repeat (3) @(negedge clk);
        checkOutput("stray_ack_count", access_count, 0);
        checkOutput("stray_ack_ready", req_ready, 1);
        applyStimulus(15'd1024, 0, 0, 32'hC0DE4400, 1);
    endtask

    initial begin : watchdog
        #3000000;
        nFails++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin : stimulus
        modelClear();
        @(negedge clk);
        doReset();

        $display("[TB] cold miss then spatial hits");
        applyStimulus(15'd1024, 3, 0, 32'hC0DE4400, 1);
        applyStimulus(15'd1025, 0, 1, 32'hC0DE4411, 1);
        applyStimulus(15'd1026, 0, 1, 32'hC0DE4422, 1);
        applyStimulus(15'd1027, 0, 1, 32'hC0DE4433, 1);
        checkOutput("cold_hit_count", hit_count, 3);
        checkOutput("cold_access_count", access_count, 4);

        $display("[TB] associativity and round-robin eviction");
        doReset();
        applyStimulus(15'd1024, 0, 0, 0, 0);
        applyStimulus(15'd1536, 0, 0, 0, 0);
        applyStimulus(15'd1024, 0, 1, 0, 0);
        applyStimulus(15'd1536, 0, 1, 0, 0);
        applyStimulus(15'd2048, 0, 0, 0, 0);
        applyStimulus(15'd1024, 0, 0, 0, 0);
        applyStimulus(15'd2048, 0, 1, 0, 0);
        applyStimulus(15'd1536, 0, 0, 0, 0);

        $display("[TB] slow memory acknowledge");
        doReset();
        applyStimulus(15'd1024, 10, 0, 32'hC0DE4400, 1);

        $display("[TB] reset during fetch");
        doReset();
        resetMidFetch();

        $display("[TB] counter saturation");
        doReset();
        applyStimulus(15'd1024, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(15'(1024 + (i % 4)), 0, 1, 0, 0);
        checkOutput("sat_hits_lit", satHitCount, 15);
        checkOutput("sat_access_lit", satAccCount, 15);
        checkOutput("wide_hits_lit", hit_count, 20);
        checkOutput("wide_access_lit", access_count, 21);

        $display("[TB] sequential sweep");
        doReset();
        for (int a = 1024; a <= 9215; a++) applyStimulus(15'(a), 0, -1, 0, 0);
        checkOutput("sweep_access_count", access_count, 8192);
        checkOutput("sweep_hit_count", hit_count, 6144);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
